// File: rtl/cr_cceip_64_sa_drain_pkg.sv
// Shared types for the stats-aggregator drain: FSM states and the two output word layouts.
package cr_cceip_64_sa_drain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        WAIT,
        HDR,
        DATA
    } drain_state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef struct packed {
        logic [7:0]  magic;
        logic [15:0] module_id;
        logic [15:0] seq;
        logic [7:0]  n_counters;
        logic [15:0] rsvd;
    } hdr_word_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [7:0]  rsvd;
        logic [49:0] value;
    } cnt_word_t;

endpackage

// File: rtl/cr_cceip_64_sa_drain_timer.sv
// Periodic dump timer: pulses expire every cfg_period cycles, held cleared while cfg_period is 0.
module cr_cceip_64_sa_drain_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cfg_period,
    output logic        expire
);

    logic [31:0] count;

    // Compare with >= so a period shrunk below the running count fires straight away.
    assign expire = (cfg_period != 32'd0) && (count >= (cfg_period - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if ((cfg_period == 32'd0) || expire) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/cr_cceip_64_sa_drain.sv
// Snapshot drain: snaps the aggregator counters on a trigger, then streams a header plus one word per counter.
module cr_cceip_64_sa_drain
    import cr_cceip_64_sa_drain_pkg::*;
#(
    parameter int N_COUNTERS      = 64,
    parameter int CNT_WIDTH       = 50,
    parameter int SNAP_WAIT       = 2,
    parameter int SEQ_WIDTH       = 16,
    parameter int MODULE_ID_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [31:0]                       cfg_period,
    input  logic [MODULE_ID_WIDTH-1:0]        cfg_module_id,
    input  logic                              sw_trigger,
    input  logic [N_COUNTERS*CNT_WIDTH-1:0]   sa_snapshot,
    output logic                              drain_snap,
    output logic                              drain_valid,
    input  logic                              drain_ready,
    output logic [63:0]                       drain_data,
    output logic                              drain_last,
    output logic                              drain_busy,
    output logic [15:0]                       drain_missed
);

    localparam int IDX_W  = $clog2(N_COUNTERS);
    localparam int WAIT_W = $clog2(SNAP_WAIT + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_COUNTERS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SNAP_WAIT - 1);

    drain_state_e          state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [SEQ_WIDTH-1:0]  seq;
    logic                  timer_expire;
    logic                  trig;
    logic [CNT_WIDTH-1:0]  snap_arr [N_COUNTERS];

    for (genvar g = 0; g < N_COUNTERS; g++) begin : g_unpack
        assign snap_arr[g] = sa_snapshot[g*CNT_WIDTH +: CNT_WIDTH];
    end

    cr_cceip_64_sa_drain_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_period (cfg_period),
        .expire     (timer_expire)
    );

    assign trig    = sw_trigger | timer_expire;
    assign idx_nxt = idx + IDX_W'(1);

    function automatic logic [63:0] hdr_word(input logic [SEQ_WIDTH-1:0] s,
                                             input logic [MODULE_ID_WIDTH-1:0] id);
        hdr_word_t h;
        h.magic      = HDR_MAGIC;
        h.module_id  = 16'(id);
        h.seq        = 16'(s);
        h.n_counters = 8'(N_COUNTERS);
        h.rsvd       = '0;
        return h;
    endfunction

    function automatic logic [63:0] cnt_word(input logic [IDX_W-1:0] i);
        cnt_word_t w;
        w.idx   = 6'(i);
        w.rsvd  = '0;
        w.value = 50'(snap_arr[i]);
        return w;
    endfunction

    // The output word is loaded together with valid or on a handshake, so the
    // next word is already registered and a tied-high ready gives one beat per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            wait_cnt     <= '0;
            seq          <= '0;
            drain_snap   <= 1'b0;
            drain_valid  <= 1'b0;
            drain_data   <= '0;
            drain_last   <= 1'b0;
            drain_busy   <= 1'b0;
            drain_missed <= '0;
        end else begin
            drain_snap <= 1'b0;
            if (trig && (state != IDLE) && (drain_missed != 16'hFFFF)) begin
                drain_missed <= drain_missed + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (trig) begin
                        state      <= SNAP;
                        drain_snap <= 1'b1;
                        drain_busy <= 1'b1;
                    end
                end
                SNAP: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state       <= HDR;
                        drain_valid <= 1'b1;
                        drain_data  <= hdr_word(seq, cfg_module_id);
                        drain_last  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HDR: begin
                    if (drain_ready) begin
                        state      <= DATA;
                        idx        <= '0;
                        drain_data <= cnt_word('0);
                        drain_last <= (IDX_LAST == '0);
                    end
                end
                DATA: begin
                    if (drain_ready) begin
                        if (idx == IDX_LAST) begin
                            state       <= IDLE;
                            drain_valid <= 1'b0;
                            drain_last  <= 1'b0;
                            drain_busy  <= 1'b0;
                            seq         <= seq + SEQ_WIDTH'(1);
                        end else begin
                            idx        <= idx_nxt;
                            drain_data <= cnt_word(idx_nxt);
                            drain_last <= (idx_nxt == IDX_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_cceip_64_sa_drain.sv
// Directed-plus-random bench for the snapshot drain against a dump-level reference model.
module tb_cr_cceip_64_sa_drain;

    localparam int N     = 64;
    localparam int CW    = 50;
    localparam int SW    = 2;
    localparam int SEQ_W = 4;
    localparam int MID_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [31:0]          cfg_period = '0;
    logic [MID_W-1:0]     cfg_module_id = '0;
    logic                 sw_trigger = 1'b0;
    logic [N*CW-1:0]      sa_snapshot = '0;
    logic                 drain_snap;
    logic                 drain_valid;
    logic                 drain_ready = 1'b1;
    logic [63:0]          drain_data;
    logic                 drain_last;
    logic                 drain_busy;
    logic [15:0]          drain_missed;

    always #5 clk = ~clk;

    cr_cceip_64_sa_drain #(
        .N_COUNTERS      (N),
        .CNT_WIDTH       (CW),
        .SNAP_WAIT       (SW),
        .SEQ_WIDTH       (SEQ_W),
        .MODULE_ID_WIDTH (MID_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_period    (cfg_period),
        .cfg_module_id (cfg_module_id),
        .sw_trigger    (sw_trigger),
        .sa_snapshot   (sa_snapshot),
        .drain_snap    (drain_snap),
        .drain_valid   (drain_valid),
        .drain_ready   (drain_ready),
        .drain_data    (drain_data),
        .drain_last    (drain_last),
        .drain_busy    (drain_busy),
        .drain_missed  (drain_missed)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rand_rdy = 1'b0;
    beat_t       beats[$];
    int          snaps[$];
    logic [CW-1:0] snap [N];
    int          exp_seq = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] hold_data = '0;
    logic        hold_last = 1'b0;

    always @(posedge clk) cyc++;

    // Beat/snap capture and hold-while-stalled checking, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (drain_snap) snaps.push_back(cyc);
            if (stall_prev) begin
                checks++;
                assert (drain_valid === 1'b1 && drain_data === hold_data && drain_last === hold_last)
                else begin
                    errors++;
                    $error("FAIL stall_hold: observed v=%b d=%h l=%b expected v=1 d=%h l=%b",
                           drain_valid, drain_data, drain_last, hold_data, hold_last);
                end
            end
            if (drain_valid && drain_ready) beats.push_back('{drain_data, drain_last, cyc});
            stall_prev = drain_valid && !drain_ready;
            hold_data  = drain_data;
            hold_last  = drain_last;
        end
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rand_rdy) drain_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pack_snap();
        for (int i = 0; i < N; i++) sa_snapshot[i*CW +: CW] = snap[i];
    endtask

    task automatic randomize_snap();
        for (int i = 0; i < N; i++) snap[i] = CW'({$urandom(), $urandom()});
        pack_snap();
    endtask

    task automatic trig_pulse(output int tcyc);
        sw_trigger = 1'b1;
        tcyc = cyc;
        step(1);
        sw_trigger = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (drain_busy && n < budget) begin
            step(1);
            n++;
        end
        chk("idle_timeout", 65'(drain_busy), 65'(0));
    endtask

    // Reference dump: header with the modelled sequence number, then idx/value words.
    task automatic compare_dump(output logic [63:0] hdr, output int hdr_cyc, output int last_cyc);
        beat_t b;
        logic [63:0] eh;
        hdr = '0;
        hdr_cyc = 0;
        last_cyc = 0;
        chk("beat_count", 65'(beats.size() >= N + 1), 65'(1));
        if (beats.size() < N + 1) return;
        eh = {8'hA5, 16'(cfg_module_id), 16'(exp_seq % (1 << SEQ_W)), 8'(N), 16'h0000};
        b = beats.pop_front();
        hdr = b.data;
        hdr_cyc = b.cyc;
        chk("header", {b.last, b.data}, {1'b0, eh});
        for (int i = 0; i < N; i++) begin
            b = beats.pop_front();
            chk($sformatf("word%0d", i), {b.last, b.data}, {(i == N - 1), 6'(i), 8'h00, 50'(snap[i])});
            if (i == N - 1) last_cyc = b.cyc;
        end
        exp_seq++;
    endtask

    initial begin
        int          tcyc;
        int          hc;
        int          lc;
        int          n;
        int          p0;
        logic [63:0] hdr;
        logic [63:0] d;

        cfg_module_id = MID_W'($urandom());
        randomize_snap();
        #2;
        chk("rst_valid", 65'(drain_valid), 65'(0));
        chk("rst_busy", 65'(drain_busy), 65'(0));
        chk("rst_snap", 65'(drain_snap), 65'(0));
        chk("rst_missed", 65'(drain_missed), 65'(0));
        chk("rst_data", {drain_last, drain_data}, 65'(0));
        step(2);
        rst_n = 1'b1;
        step(2);

        // 1: single dump at full throughput
        trig_pulse(tcyc);
        step(67);
        chk("busy_at_last", 65'(drain_busy), 65'(1));
        step(1);
        chk("busy_after_last", 65'(drain_busy), 65'(0));
        wait_idle(200);
        compare_dump(hdr, hc, lc);
        chk("snap_cycle", 65'(snaps.size() > 0 ? snaps[0] : -1), 65'(tcyc + 1));
        chk("hdr_cycle", 65'(hc), 65'(tcyc + 2 + SW));
        chk("throughput", 65'(lc - hc), 65'(N));

        // 2: max value at idx 5 under random backpressure
        randomize_snap();
        snap[5] = 50'h3_FFFF_FFFF_FFFF;
        pack_snap();
        rand_rdy = 1'b1;
        trig_pulse(tcyc);
        wait_idle(3000);
        rand_rdy = 1'b0;
        drain_ready = 1'b1;
        if (beats.size() > 6) chk("word6_value", 65'(beats[6].data), 65'(64'h1403_FFFF_FFFF_FFFF));
        compare_dump(hdr, hc, lc);

        // 3: periodic dumps every 200 cycles
        snaps.delete();
        randomize_snap();
        cfg_period = 32'd200;
        p0 = cyc;
        n = 0;
        while (snaps.size() < 3 && n < 1000) begin
            step(1);
            n++;
        end
        wait_idle(300);
        cfg_period = 32'd0;
        chk("period_snaps", 65'(snaps.size()), 65'(3));
        if (snaps.size() >= 3) begin
            chk("period_first", 65'(snaps[0]), 65'(p0 + 200));
            chk("period_gap1", 65'(snaps[1] - snaps[0]), 65'(200));
            chk("period_gap2", 65'(snaps[2] - snaps[1]), 65'(200));
        end
        for (int k = 0; k < 3; k++) compare_dump(hdr, hc, lc);

        // 4: dropped triggers during a dump, including one at the last handshake
        snaps.delete();
        randomize_snap();
        trig_pulse(tcyc);
        step(10);
        trig_pulse(tcyc);
        step(5);
        trig_pulse(tcyc);
        step(5);
        trig_pulse(tcyc);
        chk("missed_3", 65'(drain_missed), 65'(3));
        n = 0;
        d = '0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (drain_valid && drain_last) break;
        end
        chk("last_seen", 65'(drain_valid && drain_last), 65'(1));
        sw_trigger = 1'b1;
        @(posedge clk);
        #1;
        sw_trigger = 1'b0;
        chk("missed_4", 65'(drain_missed), 65'(4));
        step(10);
        chk("no_extra_busy", 65'(drain_busy), 65'(0));
        chk("no_extra_snap", 65'(snaps.size()), 65'(1));
        compare_dump(hdr, hc, lc);

        // 5: reset in the middle of the data phase
        randomize_snap();
        trig_pulse(tcyc);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            d = drain_data;
            if (drain_valid && d[63:58] == 6'd30) break;
        end
        chk("reached_idx30", 65'(d[63:58]), 65'(30));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 65'(drain_valid), 65'(0));
        chk("rst_mid_busy", 65'(drain_busy), 65'(0));
        step(2);
        rst_n = 1'b1;
        beats.delete();
        exp_seq = 0;
        chk("rst_mid_missed", 65'(drain_missed), 65'(0));
        step(2);
        trig_pulse(tcyc);
        wait_idle(200);
        compare_dump(hdr, hc, lc);

        // 6: missed counter saturation while stalled on the header, then sequence wrap
        drain_ready = 1'b0;
        trig_pulse(tcyc);
        sw_trigger = 1'b1;
        step(65534);
        chk("missed_fffe", 65'(drain_missed), 65'(16'hFFFE));
        step(3);
        chk("missed_sat", 65'(drain_missed), 65'(16'hFFFF));
        sw_trigger = 1'b0;
        drain_ready = 1'b1;
        wait_idle(200);
        compare_dump(hdr, hc, lc);
        for (int k = 0; k < 15; k++) begin
            randomize_snap();
            rand_rdy = (k % 3 == 0);
            trig_pulse(tcyc);
            wait_idle(2000);
            rand_rdy = 1'b0;
            drain_ready = 1'b1;
            compare_dump(hdr, hc, lc);
        end
        chk("seq_wrap", 65'(hdr[39:24]), 65'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
